// File: rtl/shop_pkg.sv
// Shared definitions for the upgrade-shop purchase initiator.
// Holds status codes, FSM state encoding and default timing parameters.
package shop_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    localparam logic [1:0] STAT_IDLE = 2'b00;
    localparam logic [1:0] STAT_OK   = 2'b01;
    localparam logic [1:0] STAT_POOR = 2'b10;
    localparam logic [1:0] STAT_MAX  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } shop_state_t;

    // Outcome when the wallet never answered: a maxed upgrade explains the silence
    function automatic logic [1:0] timeoutStatus(input logic maxed);
        return maxed ? STAT_MAX : STAT_POOR;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Buy-button conditioning: two-flop synchronizer, stability counter and
// rising-edge detector producing a one-cycle press event.
module btn_debouncer
    import shop_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_levelDly;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw button into the clock domain before anything looks at it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the level only after the input has disagreed for a full stable run
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered rising-edge detect of the debounced level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_levelDly <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_levelDly <= r_level;
            r_press    <= r_level & ~r_levelDly;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/shop_ctrl.sv
// Upgrade-shop purchase initiator: turns a debounced button press into one
// tick-aligned purchase request, waits a bounded window for the wallet's
// answer and records OK / POOR / MAX plus a saturating success count.
// Optional build macro: SHOP_PRECHECK_EN (local affordability check in IDLE).
module shop_ctrl
    import shop_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int COUNT_W         = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_gameClk,
    input  logic               i_btnBuy,
    input  logic               i_buySucc,
    input  logic               i_maxed,
    input  logic [11:0]        i_balance,
    input  logic [11:0]        i_unitCost,
    output logic               o_purchase,
    output logic               o_busy,
    output logic [1:0]         o_status,
    output logic [COUNT_W-1:0] o_buyCount
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    logic               w_level;
    logic               w_press;
    shop_state_t        r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_purchase;
    logic               r_busy;
    logic [1:0]         r_status;
    logic [COUNT_W-1:0] r_buyCount;

`ifndef SHOP_PRECHECK_EN
    // Price inputs only matter when the local affordability check is built in
    logic w_unusedPrice;
    assign w_unusedPrice = ^{i_balance, i_unitCost};
`endif

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btnBuy),
        .o_level(w_level),
        .o_press(w_press)
    );

    // Purchase sequencer: all outputs are registered so the wallet and display see clean levels
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_purchase <= 1'b0;
            r_busy     <= 1'b0;
            r_status   <= STAT_IDLE;
            r_buyCount <= '0;
        end else begin
            r_purchase <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        if (i_maxed) begin
                            r_status <= STAT_MAX;
                            r_state  <= ST_HOLD;
                        end
`ifdef SHOP_PRECHECK_EN
                        else if (i_balance < i_unitCost) begin
                            r_status <= STAT_POOR;
                            r_state  <= ST_HOLD;
                        end
`endif
                        else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (i_maxed) begin
                        r_status <= STAT_MAX;
                        r_busy   <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else if (i_gameClk) begin
                        r_purchase <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_buySucc) begin
                        r_status <= STAT_OK;
                        if (r_buyCount != {COUNT_W{1'b1}}) begin
                            r_buyCount <= r_buyCount + COUNT_W'(1);
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_HOLD;
                    end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        r_status <= timeoutStatus(i_maxed);
                        r_busy   <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_HOLD: begin
                    r_busy <= 1'b0;
                    if (!w_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_purchase = r_purchase;
    assign o_busy     = r_busy;
    assign o_status   = r_status;
    assign o_buyCount = r_buyCount;

endmodule

// File: tb/tb_shop_ctrl.sv
// Self-checking bench for shop_ctrl: table of purchase scenarios, hand-written
// bounce and reset-in-WAIT sequences, then random scenarios scored by a
// transaction-level outcome model. Honours SHOP_PRECHECK_EN if defined.
module tb_shop_ctrl;
    import shop_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 8;
    localparam int CW  = 3;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int RUN_CYCLES = 45;
    localparam int RELEASE_CYCLES = 12;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_gameClk;
    logic          i_btnBuy;
    logic          i_buySucc;
    logic          i_maxed;
    logic [11:0]   i_balance;
    logic [11:0]   i_unitCost;
    logic          o_purchase;
    logic          o_busy;
    logic [1:0]    o_status;
    logic [CW-1:0] o_buyCount;

    int checks = 0;
    int errors = 0;

    // Wallet emulation state
    logic maxedBase = 1'b0;
    logic maxedLate = 1'b0;
    int   respDelay = 0;
    bit   maxedInWait = 1'b0;
    int   purchaseTotal = 0;
    int   trialBase = 0;
    int   sinceP = -1;
    int   busyAfterP = 0;
    bit   trackBounce = 1'b0;
    bit   bounceBusy = 1'b0;

    // Model state
    int successCount = 0;

    typedef struct {
        bit         maxedAtPress;
        int         respDelay;
        bit         maxedInWait;
        int         balance;
        int         cost;
        logic [1:0] expStatus;
        int         expPurchases;
    } vec_t;

    assign i_maxed = maxedBase | maxedLate;

    shop_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .COUNT_W        (CW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_gameClk (i_gameClk),
        .i_btnBuy  (i_btnBuy),
        .i_buySucc (i_buySucc),
        .i_maxed   (i_maxed),
        .i_balance (i_balance),
        .i_unitCost(i_unitCost),
        .o_purchase(o_purchase),
        .o_busy    (o_busy),
        .o_status  (o_status),
        .o_buyCount(o_buyCount)
    );

    // 100 MHz-style clock
    always #5 i_clk = ~i_clk;

    // Game tick: one-cycle pulse every ten clocks
    initial begin
        i_gameClk = 1'b0;
        forever begin
            repeat (9) @(negedge i_clk);
            i_gameClk = 1'b1;
            @(negedge i_clk);
            i_gameClk = 1'b0;
        end
    end

    // Wallet: watches purchase, answers after respDelay cycles, optionally goes maxed during the wait
    initial begin
        i_buySucc = 1'b0;
        forever begin
            @(negedge i_clk);
            i_buySucc = 1'b0;
            if (o_purchase === 1'b1) begin
                purchaseTotal++;
                sinceP = 0;
                busyAfterP = 0;
            end else if (sinceP >= 0) begin
                sinceP++;
                if (o_busy === 1'b1) busyAfterP++;
            end
            if (respDelay > 0 && sinceP == respDelay && purchaseTotal > trialBase) i_buySucc = 1'b1;
            maxedLate = maxedInWait && sinceP >= 1 && purchaseTotal > trialBase;
            if (trackBounce && o_busy === 1'b1) bounceBusy = 1'b1;
        end
    end

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycle();
        @(negedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    function automatic int expCount();
        return (successCount > CNT_MAX) ? CNT_MAX : successCount;
    endfunction

    // Outcome model: what the shop rules say should happen for one press
    function automatic vec_t refModel(input vec_t v);
        vec_t r;
        bit precheck;
`ifdef SHOP_PRECHECK_EN
        precheck = 1'b1;
`else
        precheck = 1'b0;
`endif
        r = v;
        if (v.maxedAtPress) begin
            r.expStatus = STAT_MAX;
            r.expPurchases = 0;
        end else if (precheck && v.balance < v.cost) begin
            r.expStatus = STAT_POOR;
            r.expPurchases = 0;
        end else begin
            r.expPurchases = 1;
            if (v.respDelay >= 1 && v.respDelay <= TMO) r.expStatus = STAT_OK;
            else if (v.maxedInWait) r.expStatus = STAT_MAX;
            else r.expStatus = STAT_POOR;
        end
        return r;
    endfunction

    task automatic applyStimulus(input string tag, input vec_t v);
        int p0;
        p0 = purchaseTotal;
        trialBase = purchaseTotal;
        maxedBase = v.maxedAtPress;
        respDelay = v.respDelay;
        maxedInWait = v.maxedInWait;
        i_balance = 12'(v.balance);
        i_unitCost = 12'(v.cost);
        i_btnBuy = 1'b1;
        repeat (RUN_CYCLES) stepCycle();
        if (v.expStatus == STAT_OK && v.expPurchases == 1) successCount++;
        checkOutput({tag, ".status"}, 32'(o_status), 32'(v.expStatus));
        checkOutput({tag, ".purchases"}, purchaseTotal - p0, v.expPurchases);
        checkOutput({tag, ".buyCount"}, 32'(o_buyCount), expCount());
        checkOutput({tag, ".busyHold"}, 32'(o_busy), 0);
        if (v.expPurchases == 1)
            checkOutput({tag, ".busyWindow"}, busyAfterP, (v.expStatus == STAT_OK) ? v.respDelay : TMO);
        i_btnBuy = 1'b0;
        maxedInWait = 1'b0;
        repeat (RELEASE_CYCLES) stepCycle();
        maxedBase = 1'b0;
        respDelay = 0;
        checkOutput({tag, ".statusPersist"}, 32'(o_status), 32'(v.expStatus));
    endtask

    vec_t table_v[10];

    initial begin
        int p0;
        bit reached;
        vec_t rv;

        table_v[0] = '{1'b0, 3, 1'b0, 0, 0, STAT_OK, 1};
        table_v[1] = '{1'b0, 0, 1'b0, 0, 0, STAT_POOR, 1};
        table_v[2] = '{1'b1, 3, 1'b0, 0, 0, STAT_MAX, 0};
        table_v[3] = '{1'b1, 3, 1'b0, 0, 0, STAT_MAX, 0};
        table_v[4] = '{1'b0, 8, 1'b0, 0, 0, STAT_OK, 1};
        table_v[5] = '{1'b0, 9, 1'b0, 0, 0, STAT_POOR, 1};
        table_v[6] = '{1'b0, 0, 1'b1, 0, 0, STAT_MAX, 1};
        table_v[7] = '{1'b0, 1, 1'b0, 0, 0, STAT_OK, 1};
`ifdef SHOP_PRECHECK_EN
        table_v[8] = '{1'b0, 4, 1'b0, 5, 10, STAT_POOR, 0};
`else
        table_v[8] = '{1'b0, 4, 1'b0, 5, 10, STAT_OK, 1};
`endif
        table_v[9] = '{1'b0, 2, 1'b1, 20, 3, STAT_OK, 1};

        i_rst = 1'b1;
        i_btnBuy = 1'b0;
        i_balance = '0;
        i_unitCost = '0;
        repeat (3) stepCycle();
        checkOutput("reset.purchase", 32'(o_purchase), 0);
        checkOutput("reset.busy", 32'(o_busy), 0);
        checkOutput("reset.status", 32'(o_status), 32'(STAT_IDLE));
        checkOutput("reset.buyCount", 32'(o_buyCount), 0);
        i_rst = 1'b0;
        repeat (2) stepCycle();

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("table%0d", i), table_v[i]);
        end

        // Bounce: rapid toggling must not produce a press; the settled level must
        trialBase = purchaseTotal;
        p0 = purchaseTotal;
        bounceBusy = 1'b0;
        trackBounce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_btnBuy = ~i_btnBuy;
            repeat (2) stepCycle();
        end
        trackBounce = 1'b0;
        checkOutput("bounce.purchases", purchaseTotal - p0, 0);
        checkOutput("bounce.busy", 32'(bounceBusy), 0);
        respDelay = 2;
        i_btnBuy = 1'b1;
        repeat (RUN_CYCLES) stepCycle();
        successCount++;
        checkOutput("settled.purchases", purchaseTotal - p0, 1);
        checkOutput("settled.status", 32'(o_status), 32'(STAT_OK));
        checkOutput("settled.buyCount", 32'(o_buyCount), expCount());
        i_btnBuy = 1'b0;
        repeat (RELEASE_CYCLES) stepCycle();
        respDelay = 0;

        // Reset while waiting for the wallet; its late answer must be ignored
        trialBase = purchaseTotal;
        p0 = purchaseTotal;
        respDelay = 6;
        i_btnBuy = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            stepCycle();
            if (purchaseTotal != p0 && sinceP == 2) reached = 1'b1;
        end
        checkOutput("rstWait.reached", 32'(reached), 1);
        i_rst = 1'b1;
        i_btnBuy = 1'b0;
        stepCycle();
        i_rst = 1'b0;
        successCount = 0;
        checkOutput("rstWait.purchase", 32'(o_purchase), 0);
        checkOutput("rstWait.busy", 32'(o_busy), 0);
        checkOutput("rstWait.status", 32'(o_status), 32'(STAT_IDLE));
        checkOutput("rstWait.buyCount", 32'(o_buyCount), 0);
        repeat (10) stepCycle();
        checkOutput("lateSucc.status", 32'(o_status), 32'(STAT_IDLE));
        checkOutput("lateSucc.buyCount", 32'(o_buyCount), 0);
        checkOutput("lateSucc.busy", 32'(o_busy), 0);
        respDelay = 0;

        // Random scenarios scored by the outcome model; enough successes to saturate the counter
        for (int i = 0; i < 24; i++) begin
            rv.maxedAtPress = ($urandom_range(0, 5) == 0);
            rv.respDelay = int'($urandom_range(0, 11));
            rv.maxedInWait = bit'($urandom_range(0, 1));
            rv.balance = int'($urandom_range(0, 20));
            rv.cost = int'($urandom_range(0, 20));
            rv.expStatus = STAT_IDLE;
            rv.expPurchases = 0;
            rv = refModel(rv);
            applyStimulus($sformatf("rand%0d", i), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shop_ctrl.md
# shop_ctrl

Purchase initiator for the clicker game's upgrade shop: debounces the buy button and issues a single-cycle `purchase` request to the wallet, aligned to a game tick. It then waits a bounded window for the wallet's `buySucc` response and classifies the outcome as OK, POOR or MAX. The result is held on `status` for the seven-segment/VGA layer in the top level, and successful buys are counted.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable `clk` cycles required before the debounced button changes (5 ms at 100 MHz).
- `TIMEOUT_CYCLES`, 1024: response window after the request, in `clk` cycles, ≥2.
- `COUNT_W`, 8: width of `buyCount`.
- `clk` in 1: system clock (ClkPort domain); the only clock.
- `rst` in 1: synchronous, active-high reset.
- `gameClk` in 1: game tick, a one-`clk`-wide enable pulse.
- `btnBuy` in 1: raw button level, asynchronous to `clk`.
- `buySucc` in 1: wallet success pulse, one cycle wide.
- `maxed` in 1: wallet level flag; upgrade at maximum level.
- `balance` in 12: current wallet balance, unsigned.
- `unitCost` in 12: cost of the next upgrade, unsigned.
- `purchase` out 1: request pulse to the wallet.
- `busy` out 1: high from press acceptance until the outcome is recorded.
- `status` out 2: 00 IDLE, 01 OK, 10 POOR, 11 MAX.
- `buyCount` out COUNT_W: count of successful purchases; saturating.

## Operation
- **Button path:**
  - Two-flop synchronizer, then debouncer.
  - The debounced level toggles only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level is a one-cycle `press` event.
- **FSM states:** IDLE, ARM, REQ, WAIT, HOLD.
- **IDLE:**
  - On `press`, if `maxed` = 1: status := MAX, go to HOLD. No request is issued.
  - Otherwise go to ARM, `busy` = 1.
- **ARM:**
  - Wait for `gameClk` = 1, then go to REQ on the next edge.
  - If `maxed` rises while in ARM: status := MAX, go to HOLD.
- **REQ:** `purchase` = 1 for exactly this one cycle. Clear the timer, go to WAIT.
- **WAIT:**
  - The timer increments each cycle.
  - `buySucc` = 1: status := OK, `buyCount` += 1 (holds at all-ones), go to HOLD.
  - Timer reaches `TIMEOUT_CYCLES`-1 without `buySucc`: status := MAX if `maxed`, else POOR; go to HOLD.
  - `buySucc` and timeout on the same cycle: success wins.
- **HOLD:**
  - `busy` = 0.
  - Stay until the debounced button is low, then go to IDLE. This gives exactly one purchase per press.
- **Status persistence:** `status` holds the last outcome through IDLE. It is overwritten only when the next outcome is recorded.
- **Ignored events:**
  - `press` outside IDLE.
  - `buySucc` outside WAIT, including the REQ cycle itself.
- `balance`/`unitCost` are 12-bit unsigned; the comparison is unsigned; no arithmetic on them.

## Timing
- **Reset values:**
  - `purchase` 0, `busy` 0, `status` 00, `buyCount` 0.
  - FSM IDLE, debounced level 0, sync flops 0, timers 0.
- **Press latency:** `btnBuy` rise to `press` = 2 sync cycles + `DEBOUNCE_CYCLES` + 1.
- **IDLE→ARM:** 1 cycle after `press`.
- **Request latency:** `purchase` is asserted in the cycle after the first `gameClk` seen in ARM. This includes a `gameClk` present on the ARM entry cycle.
- **Response window:** `buySucc` is accepted in the cycles after `purchase`, for `TIMEOUT_CYCLES` cycles total.
- **Outcome update:** `status`/`buyCount` update on the edge that leaves WAIT. `busy` falls on that same edge.
- **Reset mid-operation:** `rst` in any state returns all reset values on the next edge. A `purchase` already issued is not retracted, and a late `buySucc` is ignored.

## Configuration
- `SHOP_PRECHECK_EN`:
  - **Defined:** in IDLE, a `press` with `maxed` = 0 and `balance` < `unitCost` sets status := POOR and goes to HOLD. No `purchase` is issued, and `busy` stays 0.
  - **Undefined:** no affordability check; the wallet decides, and the timeout path reports POOR.

## Structure
- **Shared package `shop_pkg`:**
  - Status encodings STAT_IDLE/OK/POOR/MAX.
  - FSM state encodings.
  - Default `DEBOUNCE_CYCLES`/`TIMEOUT_CYCLES`.
- **Sub-module `btn_debouncer`:** synchronizer + debounce counter + rising-edge detect. Parameter `DEBOUNCE_CYCLES`; outputs `level` and `press`.
- **Top-level wiring:** `purchase` drives the wallet's `purchase` input; `status`/`buyCount` feed the display.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=8, `gameClk` every 10 cycles.
- **Success:** press; wallet pulses `buySucc` 3 cycles after `purchase` → one `purchase` pulse, `status`=01, `buyCount`=1, `busy` falls the same edge.
- **Bounce:** button toggling every 2 cycles for 20 cycles, then held → zero presses during the bounce, one `purchase` after it settles.
- **No response:** press with `maxed`=0 and no `buySucc` → `status`=10 exactly 8 cycles after `purchase`; `buyCount` unchanged.
- **Maxed at press:** `maxed`=1 at press → no `purchase`, `status`=11; a second press while still held yields nothing.
- **Boundaries:** `buySucc` on the timeout cycle → `status`=01. `rst` asserted in WAIT → all outputs at reset values next cycle; a later `buySucc` is ignored.
- **Precheck:** with `SHOP_PRECHECK_EN`, `balance`=5, `unitCost`=10 → `status`=10, no `purchase`. Without it → `purchase` issued.
